// File: rtl/mzsync_gen.sv
// mzsync_gen: regenerates composite-monitor nHSYNC/nVSYNC from the
// MZ-80B nHBLANK/nVBLANK pair, with a prescaled delay and pulse width.
// Ports:
//   CLK          50 MHz system clock
//   RST          synchronous active-high reset
//   nHBLANK      horizontal blank in, active low, asynchronous
//   nVBLANK      vertical blank in, active low, asynchronous
//   nHSYNC       regenerated horizontal sync, active low, registered
//   nVSYNC       regenerated vertical sync, active low, registered
//   FIELD        toggles on every nVSYNC falling edge
//   LOST         sticky: trigger arrived while its channel was busy
//   LOSTCLR      synchronous clear for LOST (a coincident set wins)
module mzsync_gen #(
    parameter int PRESCALE  = 16,
    parameter int CNT_W     = 13,
    parameter int HSYNC_ON  = 25,
    parameter int HSYNC_OFF = 40,
    parameter int VSYNC_ON  = 3437,
    parameter int VSYNC_OFF = 6562
) (
    input  logic CLK,
    input  logic RST,
    input  logic nHBLANK,
    input  logic nVBLANK,
    output logic nHSYNC,
    output logic nVSYNC,
    output logic FIELD,
    output logic LOST,
    input  logic LOSTCLR
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    // cnt increments on the tick itself, so the tick that lands on
    // ON*PRESCALE clocks after the trigger sees cnt == ON-1.
    localparam logic [CNT_W-1:0] H_ON_LAST  = CNT_W'(HSYNC_ON - 1);
    localparam logic [CNT_W-1:0] H_OFF_LAST = CNT_W'(HSYNC_OFF - 1);
    localparam logic [CNT_W-1:0] V_ON_LAST  = CNT_W'(VSYNC_ON - 1);
    localparam logic [CNT_W-1:0] V_OFF_LAST = CNT_W'(VSYNC_OFF - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    // Channel index 0 is H, 1 is V.
    logic [1:0]       blank_n;
    logic [1:0]       meta_q, meta_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       fill_q, fill_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       armed_q, armed_d;
    logic [1:0]       nsync_q, nsync_d;
    logic [1:0]       state_q [2];
    logic [1:0]       state_d [2];
    logic [PW-1:0]    pre_q [2];
    logic [PW-1:0]    pre_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [CNT_W-1:0] on_last [2];
    logic [CNT_W-1:0] off_last [2];
    logic             field_q, field_d;
    logic             lost_q, lost_d;
    logic [1:0]       trig;
    logic [1:0]       late;
    logic [1:0]       fall;

    assign blank_n     = {nVBLANK, nHBLANK};
    assign on_last[0]  = H_ON_LAST;
    assign on_last[1]  = V_ON_LAST;
    assign off_last[0] = H_OFF_LAST;
    assign off_last[1] = V_OFF_LAST;

    always_comb begin
        meta_d  = blank_n;
        s_d     = meta_q;
        prev_d  = s_q;
        // fill_q[1] marks s_q as carrying real input rather than the
        // reset value, so a blank held low through reset never arms.
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (s_q & {2{fill_q[1]}});
        trig    = armed_q & prev_q & ~s_q;
        nsync_d = nsync_q;
        late    = 2'b00;
        fall    = 2'b00;
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            pre_d[c]   = pre_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (trig[c]) begin
                        state_d[c] = ST_DELAY;
                        pre_d[c]   = '0;
                        cnt_d[c]   = '0;
                    end
                end
                ST_DELAY, ST_PULSE: begin
                    late[c] = trig[c];
                    if (pre_q[c] != PRE_LAST) begin
                        pre_d[c] = pre_q[c] + PW'(1);
                    end else begin
                        pre_d[c] = '0;
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                        if (state_q[c] == ST_DELAY &&
                            cnt_q[c] == on_last[c]) begin
                            state_d[c] = ST_PULSE;
                            nsync_d[c] = 1'b0;
                            fall[c]    = 1'b1;
                        end else if (state_q[c] == ST_PULSE &&
                                     cnt_q[c] == off_last[c]) begin
                            state_d[c] = ST_IDLE;
                            nsync_d[c] = 1'b1;
                            cnt_d[c]   = '0;
                        end
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                    nsync_d[c] = 1'b1;
                    pre_d[c]   = '0;
                    cnt_d[c]   = '0;
                end
            endcase
        end
        field_d = field_q ^ fall[1];
        lost_d  = (lost_q & ~LOSTCLR) | (|late);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_q  <= 2'b11;
            s_q     <= 2'b11;
            prev_q  <= 2'b11;
            fill_q  <= 2'b00;
            armed_q <= 2'b00;
            nsync_q <= 2'b11;
            field_q <= 1'b0;
            lost_q  <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= ST_IDLE;
                pre_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            meta_q  <= meta_d;
            s_q     <= s_d;
            prev_q  <= prev_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            nsync_q <= nsync_d;
            field_q <= field_d;
            lost_q  <= lost_d;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                pre_q[c]   <= pre_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    assign nHSYNC = nsync_q[0];
    assign nVSYNC = nsync_q[1];
    assign FIELD  = field_q;
    assign LOST   = lost_q;

endmodule

// File: doc/mzsync_gen.md
Name: mzsync_gen

Overview:
- Regenerates composite-monitor sync from the MZ-80B blanking pair. Sits beside the GVRAM pixel pipeline and consumes the same nHBLANK/nVBLANK inputs as the colour output stage.
- Each channel detects the start of blanking (a falling edge) and issues an active-low sync pulse at a fixed, prescaled delay: nominal 8 us on / 4.7 us wide for H, 1.1 ms on / 1 ms wide for V.
- Drives nHSYNC/nVSYNC toward the MZ-2000 monitor connector, plus a field-parity toggle and a lost-trigger flag for debug test points.

Parameters:
- PRESCALE, 16, system clocks per timing tick (50 MHz/16 = 320 ns tick); legal range 1..256.
- CNT_W, 13, width of each channel's tick counter.
- HSYNC_ON, 25, ticks from H-blank start to nHSYNC falling.
- HSYNC_OFF, 40, ticks from H-blank start to nHSYNC rising.
- VSYNC_ON, 3437, ticks from V-blank start to nVSYNC falling.
- VSYNC_OFF, 6562, ticks from V-blank start to nVSYNC rising.
- Legality: 1 <= *_ON < *_OFF < 2^CNT_W.

Ports:
- CLK input 1: 50 MHz system clock.
- RST input 1: reset, synchronous, active-high.
- nHBLANK input 1: horizontal blank from the MZ-80B, active low, asynchronous to CLK.
- nVBLANK input 1: vertical blank from the MZ-80B, active low, asynchronous to CLK.
- nHSYNC output 1: regenerated horizontal sync, active low, registered.
- nVSYNC output 1: regenerated vertical sync, active low, registered.
- FIELD output 1: toggles on every nVSYNC falling edge.
- LOST output 1: sticky flag; set when a trigger arrives while its channel is busy.
- LOSTCLR input 1: synchronous clear for LOST.

Behaviour:
- One clock (CLK), one reset (RST). Reset is synchronous, active-high, and is sampled only on the CLK rising edge.
- Input conditioning: each blank input passes through a 2-FF synchronizer; the sync registers reset to 1. Call the second-stage output sH / sV.
- Edge detect:
  - prev register per channel, reset to 1.
  - trig = prev & ~s (high-to-low of the synchronized blank).
- Arming:
  - Per-channel ARMED flag, reset 0.
  - Set on the first cycle s==1.
  - trig is ignored while ARMED==0, so a blank held low through reset release generates no sync.
- Channel FSM (independent, identical for H and V; states IDLE, DELAY, PULSE):
  - IDLE: on armed trig -> DELAY; clear the channel prescaler and tick counter.
  - DELAY: the prescaler counts 0..PRESCALE-1; the wrap cycle is a tick and increments cnt. When cnt==*_ON and a tick occurs, -> PULSE and drive nSYNC low on the same edge.
  - PULSE: keep counting. When cnt==*_OFF and a tick occurs, -> IDLE, nSYNC high, prescaler and cnt cleared.
- Timing contract:
  - Let Td be the CLK edge at which trig is first high.
  - nSYNC falls on edge Td + ON*PRESCALE and rises on edge Td + OFF*PRESCALE.
  - Td is 3 edges after the raw input falls, with the input set up to the edge.
  - Pulse width is exactly (OFF-ON)*PRESCALE clocks; no jitter.
- The rising edge of blank (end of blank) has no effect on any state.
- Retrigger: an armed trig in DELAY or PULSE does not restart or alter timing and sets LOST=1. LOST stays 1 until LOSTCLR; if set and clear coincide, set wins.
- FIELD:
  - Reset 0.
  - Inverts on the edge where nVSYNC goes 1->0.
- Simultaneous H and V triggers are handled independently; a V pulse does not suppress H pulses.
- Counter width: cnt never exceeds *_OFF, so no wrap-around is possible with legal parameters.
- Reset values: nHSYNC=1, nVSYNC=1, FIELD=0, LOST=0, both FSMs IDLE, counters 0, ARMED=0.
- Reset mid-pulse returns the outputs high on the next edge; no partial pulse resumes afterwards.

Test Plan (bench parameters PRESCALE=2, HSYNC_ON=3, HSYNC_OFF=5, VSYNC_ON=4, VSYNC_OFF=9 unless noted):
- Basic H sync: hold RST 2 clk with nHBLANK=1; then drop nHBLANK at edge E -> nHSYNC low from edge E+3+6 to E+3+10 (4 clocks low); nVSYNC stays 1; LOST=0.
- V sync and field parity: two nVBLANK falling edges 40 clocks apart -> each gives nVSYNC low for exactly 10 clocks starting 8 clocks after its Td; FIELD reads 1 after the first pulse and 0 after the second.
- Retrigger: pulse nHBLANK low/high/low 2 clocks apart while in DELAY -> a single nHSYNC pulse timed from the first edge; LOST=1; LOSTCLR one clock -> LOST=0; LOSTCLR coincident with a new lost trig -> LOST stays 1.
- Arming after reset: nHBLANK held 0 during and 20 clocks after RST release -> no nHSYNC pulse. After nHBLANK rises and falls again -> a normal pulse.
- Reset mid-operation: assert RST during PULSE -> nHSYNC=1 at the next edge; FIELD=0, LOST=0; no further pulse until a fresh falling edge after re-arming.
- Default parameters, 50 MHz clock: 64 us line with 11 us blank -> nHSYNC falls 8.0 us (400 clk) and rises 12.8 us (640 clk) after Td; the measured period equals the input period.
